// File: rtl/ama_riscv_dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ama_riscv_dmem_arb_pkg
// Purpose  : Shared types and constants for the data-memory arbiter.
//            arb_state_t - arbiter FSM states (IDLE / WAIT / HOLD)
//            owner_t     - owner of the access issued in a given cycle
// Revision : 1.0 - initial release
// ============================================================================
package ama_riscv_dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,    // no debug request outstanding
        WAIT = 2'd1,    // debug request blocked by core traffic
        HOLD = 2'd2     // debug starved, core asked to stall
    } arb_state_t;

    typedef enum logic {
        CORE = 1'b0,
        DBG  = 1'b1
    } owner_t;

    localparam int DEFAULT_STARVE_LIMIT = 8;

endpackage
`default_nettype wire

// File: rtl/ama_riscv_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ama_riscv_sat_cnt
// Purpose  : Up-counter that saturates at MAX instead of wrapping.
// Ports    : clk, rst (async, active-high)
//            inc    - increment by one (ignored once at MAX)
//            clr    - synchronous clear, has priority over inc
//            count  - current value
//            at_max - count equals MAX
// Revision : 1.0 - initial release
// ============================================================================
module ama_riscv_sat_cnt #(
    parameter int MAX   = 8,
    parameter int WIDTH = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count  = r_count;
    assign at_max = (r_count == c_MAX);

endmodule
`default_nettype wire

// File: rtl/ama_riscv_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ama_riscv_dmem_arbiter
// Purpose  : Shares the single synchronous DMEM between the core data port
//            (fixed priority) and a debug/loader port. The debug port is
//            served in any cycle the core leaves memory idle; if it waits
//            STARVE_LIMIT cycles the core is asked to hold (core_hold).
// Ports    : clk, rst          - clock, async active-high reset
//            core_*            - core data port (rdata 1 cycle after en)
//            core_hold         - stall request to the core memory stage
//            dbg_req/we/addr/wdata - debug request, held until dbg_gnt
//            dbg_gnt           - access issued this cycle (combinational)
//            dbg_rvalid/rdata  - response, one cycle after dbg_gnt
//            mem_*             - DMEM interface (1-cycle read latency)
// Revision : 1.0 - initial release
// ============================================================================
module ama_riscv_dmem_arbiter
    import ama_riscv_dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    // core port
    input  logic              core_en,
    input  logic [3:0]        core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_hold,
    // debug port
    input  logic              dbg_req,
    input  logic [3:0]        dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    // memory port
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int               CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] c_LIM_M1 = CNT_W'(STARVE_LIMIT - 1);

    arb_state_t       r_state;
    owner_t           r_owner;
    logic             r_dbg_pend;
    logic             r_core_hold;

    logic             w_gnt;
    logic             w_contend;
    logic             w_hit;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_max;

    // Debug is issued whenever the core leaves the memory idle, whatever the
    // FSM state; the FSM only tracks how long the debug side has waited.
    assign w_gnt     = dbg_req & ~core_en & ~rst;
    assign w_contend = dbg_req & core_en;

    // The counter is zero in IDLE, so it only counts consecutive contended
    // cycles; any uncontended cycle (grant or dropped request) clears it.
    ama_riscv_sat_cnt #(
        .MAX   (STARVE_LIMIT),
        .WIDTH (CNT_W)
    ) u_starve_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (w_contend),
        .clr    (~w_contend),
        .count  (w_cnt),
        .at_max (w_cnt_max)
    );

    // This contended cycle brings the counter to the limit.
    assign w_hit = (w_cnt == c_LIM_M1) | w_cnt_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_core_hold <= 1'b0;
            r_dbg_pend  <= 1'b0;
            r_owner     <= CORE;
        end else begin
            r_dbg_pend <= w_gnt;
            r_owner    <= w_gnt ? DBG : CORE;
            case (r_state)
                IDLE: begin
                    if (w_contend) begin
                        if (w_hit) begin
                            r_state     <= HOLD;
                            r_core_hold <= 1'b1;
                        end else begin
                            r_state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!w_contend) begin
                        r_state <= IDLE;
                    end else if (w_hit) begin
                        r_state     <= HOLD;
                        r_core_hold <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!w_contend) begin
                        r_state     <= IDLE;
                        r_core_hold <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_core_hold <= 1'b0;
                end
            endcase
        end
    end

    // Memory mux: core first, then a granted debug access, else idle.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 4'b0000;
        mem_addr = dbg_addr;
        mem_din  = dbg_wdata;
        if (core_en) begin
            mem_en   = ~rst;
            mem_we   = rst ? 4'b0000 : core_we;
            mem_addr = core_addr;
            mem_din  = core_wdata;
        end else if (w_gnt) begin
            mem_en   = 1'b1;
            mem_we   = dbg_we;
        end
    end

    assign dbg_gnt    = w_gnt;
    assign core_hold  = r_core_hold;
    assign core_rdata = mem_dout;
    assign dbg_rvalid = r_dbg_pend;
    assign dbg_rdata  = (r_dbg_pend && (r_owner == DBG)) ? mem_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ama_riscv_dmem_arbiter
// Purpose  : Directed self-checking bench for ama_riscv_dmem_arbiter with a
//            behavioural byte-write DMEM (1-cycle read latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ama_riscv_dmem_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 8;

    logic              clk;
    logic              rst;
    logic              core_en;
    logic [3:0]        core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_hold;
    logic              dbg_req;
    logic [3:0]        dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    int n_checks = 0;
    int n_fail   = 0;

    ama_riscv_dmem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_en    (core_en),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_hold  (core_hold),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DMEM: read-before-write, byte enables.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_dout <= mem[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        core_en    = 1'b0;
        core_we    = 4'h0;
        core_addr  = '0;
        core_wdata = '0;
        dbg_req    = 1'b1;
        dbg_we     = 4'hF;
        dbg_addr   = 14'h10;
        dbg_wdata  = 32'h0;

        // ---- reset state (debug request pending must not leak through)
        #3;
        check("rst_core_hold", 32'(core_hold), 32'd0);
        check("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        check("rst_dbg_rdata", dbg_rdata, 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        step();
        step();
        dbg_req = 1'b0;
        rst     = 1'b0;

        // ---- idle debug write then back-to-back debug read
        dbg_req   = 1'b1;
        dbg_we    = 4'hF;
        dbg_addr  = 14'h10;
        dbg_wdata = 32'hDEADBEEF;
        #3;
        check("idle_wr_gnt", 32'(dbg_gnt), 32'd1);
        check("idle_wr_mem_en", 32'(mem_en), 32'd1);
        check("idle_wr_mem_we", 32'(mem_we), 32'hF);
        check("idle_wr_mem_addr", 32'(mem_addr), 32'h10);
        check("idle_wr_mem_din", mem_din, 32'hDEADBEEF);
        step();
        check("idle_wr_rvalid", 32'(dbg_rvalid), 32'd1);
        dbg_we = 4'h0;
        #3;
        check("idle_rd_gnt", 32'(dbg_gnt), 32'd1);
        check("idle_rd_mem_we", 32'(mem_we), 32'h0);
        step();
        check("idle_rd_rvalid", 32'(dbg_rvalid), 32'd1);
        check("idle_rd_rdata", dbg_rdata, 32'hDEADBEEF);
        dbg_req = 1'b0;
        step();
        check("idle_after_rvalid", 32'(dbg_rvalid), 32'd0);
        check("idle_after_rdata", dbg_rdata, 32'h0);

        // ---- contention: 3 core reads while debug write waits
        core_en   = 1'b1;
        core_we   = 4'h0;
        core_addr = 14'h10;
        dbg_req   = 1'b1;
        dbg_we    = 4'hF;
        dbg_addr  = 14'h20;
        dbg_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            #3;
            check("cont_gnt", 32'(dbg_gnt), 32'd0);
            check("cont_mem_addr", 32'(mem_addr), 32'h10);
            step();
            check("cont_core_rdata", core_rdata, 32'hDEADBEEF);
            check("cont_core_hold", 32'(core_hold), 32'd0);
        end
        core_en = 1'b0;
        #3;
        check("cont_gnt4", 32'(dbg_gnt), 32'd1);
        check("cont_gnt4_addr", 32'(mem_addr), 32'h20);
        check("cont_gnt4_we", 32'(mem_we), 32'hF);
        step();
        check("cont_rvalid", 32'(dbg_rvalid), 32'd1);
        check("cont_hold_after", 32'(core_hold), 32'd0);

        // ---- byte write 4'b0011 over 0xFFFFFFFF, then core read
        dbg_we    = 4'b0011;
        dbg_wdata = 32'h1234ABCD;
        #3;
        check("bw_gnt", 32'(dbg_gnt), 32'd1);
        step();
        check("bw_rvalid", 32'(dbg_rvalid), 32'd1);
        dbg_req   = 1'b0;
        core_en   = 1'b1;
        core_addr = 14'h20;
        step();
        check("bw_core_rdata", core_rdata, 32'hFFFFABCD);
        check("bw_no_rvalid", 32'(dbg_rvalid), 32'd0);
        check("bw_dbg_rdata_zero", dbg_rdata, 32'h0);

        // ---- starvation: core_hold after LIMIT contended cycles
        dbg_req  = 1'b1;
        dbg_we   = 4'h0;
        dbg_addr = 14'h10;
        for (int i = 1; i <= LIMIT; i++) begin
            #3;
            check("starve_gnt", 32'(dbg_gnt), 32'd0);
            step();
            check("starve_hold", 32'(core_hold), (i == LIMIT) ? 32'd1 : 32'd0);
        end
        #3;
        check("hold_core_served", 32'(mem_en), 32'd1);
        check("hold_core_addr", 32'(mem_addr), 32'h20);
        step();
        check("hold_stays", 32'(core_hold), 32'd1);
        check("hold_core_rdata", core_rdata, 32'hFFFFABCD);
        core_en = 1'b0;
        #3;
        check("hold_gnt", 32'(dbg_gnt), 32'd1);
        check("hold_gnt_addr", 32'(mem_addr), 32'h10);
        check("hold_still_set", 32'(core_hold), 32'd1);
        step();
        check("hold_released", 32'(core_hold), 32'd0);
        check("hold_rvalid", 32'(dbg_rvalid), 32'd1);
        check("hold_rdata", dbg_rdata, 32'hDEADBEEF);

        // ---- dropped request clears the counter
        core_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        dbg_req = 1'b0;
        step();
        dbg_req = 1'b1;
        for (int i = 0; i < LIMIT - 1; i++) step();
        check("drop_cnt_cleared", 32'(core_hold), 32'd0);
        step();
        check("drop_then_hold", 32'(core_hold), 32'd1);

        // ---- async reset while in HOLD with a grant on the port
        core_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_hold", 32'(core_hold), 32'd0);
        check("arst_gnt", 32'(dbg_gnt), 32'd0);
        check("arst_mem_en", 32'(mem_en), 32'd0);
        check("arst_rvalid", 32'(dbg_rvalid), 32'd0);
        step();
        rst     = 1'b0;
        dbg_req = 1'b0;

        // ---- async reset between grant and rvalid drops the response
        dbg_req  = 1'b1;
        dbg_we   = 4'h0;
        dbg_addr = 14'h10;
        step();
        check("arst2_rvalid_pre", 32'(dbg_rvalid), 32'd1);
        check("arst2_rdata_pre", dbg_rdata, 32'hDEADBEEF);
        dbg_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst2_rvalid", 32'(dbg_rvalid), 32'd0);
        check("arst2_rdata", dbg_rdata, 32'h0);
        step();
        rst = 1'b0;

        // ---- after reset the FSM starts from IDLE with a clear counter
        core_en = 1'b1;
        dbg_req = 1'b1;
        for (int i = 0; i < LIMIT - 1; i++) step();
        check("post_rst_no_hold", 32'(core_hold), 32'd0);
        step();
        check("post_rst_hold", 32'(core_hold), 32'd1);
        core_en = 1'b0;
        #3;
        check("post_rst_gnt", 32'(dbg_gnt), 32'd1);
        step();
        check("post_rst_release", 32'(core_hold), 32'd0);
        dbg_req = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
